// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between requesters A and B.
// Read data returns one cycle after accept and is held per port until the next read.
module bram_arbiter #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_req_valid,
    output logic                     a_req_ready,
    input  logic                     a_req_we,
    input  logic [ADDRESS_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0]    a_req_wdata,
    output logic                     a_rsp_valid,
    output logic [DATA_WIDTH-1:0]    a_rsp_rdata,
    input  logic                     b_req_valid,
    output logic                     b_req_ready,
    input  logic                     b_req_we,
    input  logic [ADDRESS_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0]    b_req_wdata,
    output logic                     b_rsp_valid,
    output logic [DATA_WIDTH-1:0]    b_rsp_rdata,
    output logic                     bram_en,
    output logic                     bram_we,
    output logic [ADDRESS_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0]    bram_din,
    input  logic [DATA_WIDTH-1:0]    bram_dout
);

    logic                     last_grant_q, last_grant_d;
    logic                     rsp_pend_q, rsp_pend_d;
    logic                     rsp_owner_q, rsp_owner_d;
    logic [DATA_WIDTH-1:0]    hold_a_q, hold_a_d;
    logic [DATA_WIDTH-1:0]    hold_b_q, hold_b_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    din_q, din_d;

    logic                     grant_a, grant_b, accept;
    logic                     sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_din;

    // On contention the port that did not win last time gets the slot.
    assign grant_a = ~rst & a_req_valid & (~b_req_valid | last_grant_q);
    assign grant_b = ~rst & b_req_valid & (~a_req_valid | ~last_grant_q);
    assign accept  = grant_a | grant_b;

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    assign sel_we   = grant_b ? b_req_we    : a_req_we;
    assign sel_addr = grant_b ? b_req_addr  : a_req_addr;
    assign sel_din  = grant_b ? b_req_wdata : a_req_wdata;

    // Idle cycles keep addr/din parked on the last granted values.
    assign bram_en   = accept;
    assign bram_we   = accept & sel_we;
    assign bram_addr = accept ? sel_addr : addr_q;
    assign bram_din  = accept ? sel_din  : din_q;

    // Gating with rst drops a read response that lands in a reset cycle.
    assign a_rsp_valid = ~rst & rsp_pend_q & ~rsp_owner_q;
    assign b_rsp_valid = ~rst & rsp_pend_q & rsp_owner_q;
    assign a_rsp_rdata = a_rsp_valid ? bram_dout : hold_a_q;
    assign b_rsp_rdata = b_rsp_valid ? bram_dout : hold_b_q;

    always_comb begin
        last_grant_d = last_grant_q;
        rsp_pend_d   = accept & ~sel_we;
        rsp_owner_d  = rsp_owner_q;
        hold_a_d     = hold_a_q;
        hold_b_d     = hold_b_q;
        addr_d       = addr_q;
        din_d        = din_q;
        if (accept) begin
            last_grant_d = grant_b;
            rsp_owner_d  = grant_b;
            addr_d       = sel_addr;
            din_d        = sel_din;
        end
        if (a_rsp_valid) hold_a_d = bram_dout;
        if (b_rsp_valid) hold_b_d = bram_dout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            rsp_pend_q   <= 1'b0;
            rsp_owner_q  <= 1'b0;
            hold_a_q     <= '0;
            hold_b_q     <= '0;
            addr_q       <= '0;
            din_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_pend_q   <= rsp_pend_d;
            rsp_owner_q  <= rsp_owner_d;
            hold_a_q     <= hold_a_d;
            hold_b_q     <= hold_b_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed cycle table, then random traffic vs a
// transaction-level model of memory, grants and read responses.
module tb_bram_arbiter;

    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req_valid, a_req_ready, a_req_we;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata;
    logic          a_rsp_valid;
    logic [DW-1:0] a_rsp_rdata;
    logic          b_req_valid, b_req_ready, b_req_we;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata;
    logic          b_rsp_valid;
    logic [DW-1:0] b_rsp_rdata;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bram_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
        .a_req_we(a_req_we), .a_req_addr(a_req_addr),
        .a_req_wdata(a_req_wdata), .a_rsp_valid(a_rsp_valid),
        .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
        .b_req_we(b_req_we), .b_req_addr(b_req_addr),
        .b_req_wdata(b_req_wdata), .b_rsp_valid(b_rsp_valid),
        .b_rsp_rdata(b_rsp_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    // BRAM: 1-cycle read latency, data_out unchanged by writes.
    logic [DW-1:0] bram_mem [64];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) bram_mem[bram_addr] <= bram_din;
            else         bram_dout <= bram_mem[bram_addr];
        end
    end

    typedef struct {
        bit r;
        bit av; bit awe; int aa; int awd;
        bit bv; bit bwe; int ba; int bwd;
        bit ear; bit ebr; bit een;
        bit earv; int eard; bit ebrv; int ebrd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, bit av, bit awe, int aa, int awd,
                               bit bv, bit bwe, int ba, int bwd,
                               bit ear, bit ebr, bit een,
                               bit earv, int eard, bit ebrv, int ebrd);
        vec_t x;
        x.r = r; x.av = av; x.awe = awe; x.aa = aa; x.awd = awd;
        x.bv = bv; x.bwe = bwe; x.ba = ba; x.bwd = bwd;
        x.ear = ear; x.ebr = ebr; x.een = een;
        x.earv = earv; x.eard = eard; x.ebrv = ebrv; x.ebrd = ebrd;
        return x;
    endfunction

    function automatic vec_t idle(bit earv, int eard, bit ebrv, int ebrd);
        return v(0, 0,0,0,0, 0,0,0,0, 0,0,0, earv,eard,ebrv,ebrd);
    endfunction

    // Transaction-level reference model.
    logic [DW-1:0] mem_m [64];
    bit  m_lg;
    bit  m_pend;
    bit  m_pown;
    int  m_pdat, m_ha, m_hb;

    function automatic int exp_grant();
        if (rst) return -1;
        if (a_req_valid && b_req_valid) return m_lg ? 0 : 1;
        if (a_req_valid) return 0;
        if (b_req_valid) return 1;
        return -1;
    endfunction

    task automatic model_step();
        int g;
        g = exp_grant();
        if (rst) begin
            m_lg = 1; m_pend = 0; m_ha = 0; m_hb = 0;
        end else begin
            if (m_pend) begin
                if (m_pown) m_hb = m_pdat;
                else        m_ha = m_pdat;
            end
            m_pend = 0;
            if (g >= 0) begin
                m_lg = (g == 1);
                if (g == 0 ? a_req_we : b_req_we) begin
                    if (g == 0) mem_m[a_req_addr] = a_req_wdata;
                    else        mem_m[b_req_addr] = b_req_wdata;
                end else begin
                    m_pend = 1;
                    m_pown = (g == 1);
                    m_pdat = (g == 0) ? int'(mem_m[a_req_addr])
                                      : int'(mem_m[b_req_addr]);
                end
            end
        end
    endtask

    task automatic chk(string nm, int cyc, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic drive(bit r, bit av, bit awe, int aa, int awd,
                         bit bv, bit bwe, int ba, int bwd);
        rst = r;
        a_req_valid = av; a_req_we = awe;
        a_req_addr = AW'(aa); a_req_wdata = DW'(awd);
        b_req_valid = bv; b_req_we = bwe;
        b_req_addr = AW'(ba); b_req_wdata = DW'(bwd);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            bram_mem[i] = '0;
            mem_m[i] = '0;
        end
        bram_dout = '0;
        m_lg = 1; m_pend = 0; m_pown = 0; m_pdat = 0; m_ha = 0; m_hb = 0;
        drive(1, 0,0,0,0, 0,0,0,0);

        // reset, A write/read addr 3
        tbl.push_back(v(1, 0,0,0,0,    0,0,0,0, 0,0,0, 0,0,0,0));
        tbl.push_back(v(1, 1,0,3,0,    0,0,0,0, 0,0,0, 0,0,0,0));
        tbl.push_back(v(0, 1,1,3,'hA5, 0,0,0,0, 1,0,1, 0,0,0,0));
        tbl.push_back(v(0, 1,0,3,0,    0,0,0,0, 1,0,1, 0,0,0,0));
        tbl.push_back(idle(1,'hA5, 0,0));
        tbl.push_back(idle(0,'hA5, 0,0));
        // preload 0x10..0x13 at addrs 0..3
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 1,1,i,'h10+i, 0,0,0,0, 1,0,1, 0,'hA5,0,0));
        // contention: last grant was A, so B first, then alternate
        tbl.push_back(v(0, 1,0,1,0, 1,0,2,0, 0,1,1, 0,'hA5,0,0));
        tbl.push_back(v(0, 1,0,1,0, 1,0,2,0, 1,0,1, 0,'hA5,1,'h12));
        tbl.push_back(v(0, 1,0,1,0, 1,0,2,0, 0,1,1, 1,'h11,0,'h12));
        tbl.push_back(v(0, 1,0,1,0, 1,0,2,0, 1,0,1, 0,'h11,1,'h12));
        tbl.push_back(idle(1,'h11, 0,'h12));
        tbl.push_back(idle(0,'h11, 0,'h12));
        // B back-to-back reads
        tbl.push_back(v(0, 0,0,0,0, 1,0,0,0, 0,1,1, 0,'h11,0,'h12));
        tbl.push_back(v(0, 0,0,0,0, 1,0,1,0, 0,1,1, 0,'h11,1,'h10));
        tbl.push_back(v(0, 0,0,0,0, 1,0,2,0, 0,1,1, 0,'h11,1,'h11));
        tbl.push_back(v(0, 0,0,0,0, 1,0,3,0, 0,1,1, 0,'h11,1,'h12));
        tbl.push_back(idle(0,'h11, 1,'h13));
        tbl.push_back(idle(0,'h11, 0,'h13));
        // A write then B read of same address
        tbl.push_back(v(0, 1,1,5,'h3C, 0,0,0,0, 1,0,1, 0,'h11,0,'h13));
        tbl.push_back(v(0, 0,0,0,0,    1,0,5,0, 0,1,1, 0,'h11,0,'h13));
        tbl.push_back(idle(0,'h11, 1,'h3C));
        // read then reset: response suppressed, A wins after reset
        tbl.push_back(v(0, 1,0,0,0, 0,0,0,0, 1,0,1, 0,'h11,0,'h3C));
        tbl.push_back(v(1, 1,0,0,0, 0,0,0,0, 0,0,0, 0,'h11,0,'h3C));
        tbl.push_back(v(0, 1,0,1,0, 1,0,2,0, 1,0,1, 0,0,0,0));
        tbl.push_back(v(0, 1,0,1,0, 1,0,2,0, 0,1,1, 1,'h11,0,0));
        tbl.push_back(idle(0,'h11, 1,'h12));
        // idle 10 cycles, then contention: last grant B so A first
        for (int i = 0; i < 10; i++) tbl.push_back(idle(0,'h11, 0,'h12));
        tbl.push_back(v(0, 1,0,3,0, 1,0,5,0, 1,0,1, 0,'h11,0,'h12));
        tbl.push_back(v(0, 1,0,3,0, 1,0,5,0, 0,1,1, 1,'h13,0,'h12));
        tbl.push_back(idle(0,'h13, 1,'h3C));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].r, tbl[i].av, tbl[i].awe, tbl[i].aa, tbl[i].awd,
                  tbl[i].bv, tbl[i].bwe, tbl[i].ba, tbl[i].bwd);
            #1;
            chk("t_a_ready", i, a_req_ready, tbl[i].ear);
            chk("t_b_ready", i, b_req_ready, tbl[i].ebr);
            chk("t_bram_en", i, bram_en, tbl[i].een);
            chk("t_a_rsp_valid", i, a_rsp_valid, tbl[i].earv);
            chk("t_a_rsp_rdata", i, a_rsp_rdata, tbl[i].eard);
            chk("t_b_rsp_valid", i, b_rsp_valid, tbl[i].ebrv);
            chk("t_b_rsp_rdata", i, b_rsp_rdata, tbl[i].ebrd);
            @(posedge clk);
            model_step();
        end

        for (int c = 0; c < 3000; c++) begin
            int g;
            bit awe, bwe;
            @(negedge clk);
            awe = ($urandom_range(0, 2) == 0);
            bwe = ($urandom_range(0, 2) == 0);
            drive(($urandom_range(0, 60) == 0),
                  ($urandom_range(0, 2) != 0), awe,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  ($urandom_range(0, 2) != 0), bwe,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            #1;
            g = exp_grant();
            chk("r_a_ready", c, a_req_ready, g == 0);
            chk("r_b_ready", c, b_req_ready, g == 1);
            chk("r_bram_en", c, bram_en, g >= 0);
            if (g >= 0) begin
                chk("r_bram_we", c, bram_we, g == 0 ? a_req_we : b_req_we);
                chk("r_bram_addr", c, bram_addr,
                    g == 0 ? a_req_addr : b_req_addr);
                if (g == 0 ? a_req_we : b_req_we)
                    chk("r_bram_din", c, bram_din,
                        g == 0 ? a_req_wdata : b_req_wdata);
            end else begin
                chk("r_bram_we", c, bram_we, 0);
            end
            chk("r_a_rsp_valid", c, a_rsp_valid, !rst && m_pend && !m_pown);
            chk("r_b_rsp_valid", c, b_rsp_valid, !rst && m_pend && m_pown);
            chk("r_a_rsp_rdata", c, a_rsp_rdata,
                (!rst && m_pend && !m_pown) ? m_pdat : m_ha);
            chk("r_b_rsp_rdata", c, b_rsp_rdata,
                (!rst && m_pend && m_pown) ? m_pdat : m_hb);
            @(posedge clk);
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
